// File: rtl/apb_mem_slave_if.sv
// APB completer-side bus bundle for apb_mem_slave.
// Carries the master-side request and the completer response.
interface apb_mem_slave_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
    parameter int APB_PROT_WIDTH = 3
);
    logic                      PSELM;
    logic                      PENABLEM;
    logic [APB_ADDR_WIDTH-1:0] PADDRM;
    logic                      PWRITEM;
    logic [APB_DATA_WIDTH-1:0] PWDATAM;
    logic [APB_PROT_WIDTH-1:0] PPROTM;
    logic [APB_STRB_WIDTH-1:0] PSTRBM;
    logic [APB_DATA_WIDTH-1:0] PRDATAM;
    logic                      PREADYM;
    logic                      PSLVERRM;

    modport master (
        output PSELM, PENABLEM, PADDRM, PWRITEM, PWDATAM, PPROTM, PSTRBM,
        input  PRDATAM, PREADYM, PSLVERRM
    );

    modport slave (
        input  PSELM, PENABLEM, PADDRM, PWRITEM, PWDATAM, PPROTM, PSTRBM,
        output PRDATAM, PREADYM, PSLVERRM
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB memory completer: word-addressed RAM with byte strobes, a fixed
// number of wait states, and address / alignment / secure-region checks.
// All outputs are registered; the completion cycle is decided one edge
// early so that PREADYM, PSLVERRM and PRDATAM come straight from flops.
module apb_mem_slave #(
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
    parameter int                        APB_PROT_WIDTH = 3,
    parameter int                        MEM_DEPTH      = 256,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        WAIT_CYCLES    = 2
) (
    input logic          PCLKM,
    input logic          PRESETM,
    apb_mem_slave_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [3:0]                cnt;
    logic [3:0]                cnt_nxt;

    // Request captured at the setup phase and held for the whole transfer.
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      nsec_q;
    logic [APB_STRB_WIDTH-1:0] strb_q;

    logic [APB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    logic                      busy;
    logic                      done;
    logic                      accept;
    logic                      abort;
    logic                      fire;

    // Control of the transfer that completes at the next edge; when the
    // setup phase and completion coincide (zero wait states) the request
    // comes straight from the bus rather than from the capture registers.
    logic [APB_ADDR_WIDTH-1:0] cur_addr;
    logic                      cur_write;
    logic [APB_DATA_WIDTH-1:0] cur_wdata;
    logic                      cur_nsec;
    logic [APB_STRB_WIDTH-1:0] cur_strb;
    logic [APB_ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]          idx;
    logic                      err;

    assign bus.PRDATAM  = prdata;
    assign bus.PREADYM  = pready;
    assign bus.PSLVERRM = pslverr;

    // Next-state, wait counter and completion decode.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = busy && pready;
        accept    = bus.PSELM && !bus.PENABLEM && ((state == ST_IDLE) || done);
        abort     = busy && !pready && !bus.PSELM;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        if (accept) begin
            state_nxt = ST_SETUP;
            cnt_nxt   = 4'(WAIT_CYCLES);
        end else if (done || abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (busy) begin
            state_nxt = ST_ACCESS;
            cnt_nxt   = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
        end
        fire = (state_nxt != ST_IDLE) && (cnt_nxt == 4'd0);

        cur_addr  = accept ? bus.PADDRM    : addr_q;
        cur_write = accept ? bus.PWRITEM   : write_q;
        cur_wdata = accept ? bus.PWDATAM   : wdata_q;
        cur_nsec  = accept ? bus.PPROTM[1] : nsec_q;
        cur_strb  = accept ? bus.PSTRBM    : strb_q;

        // BASE_ADDR is window-aligned, so with no borrow the offset is in
        // range exactly when its bits above the word index are zero.
        offset = cur_addr - BASE_ADDR;
        idx    = offset[IDX_W+1:2];
        err    = (offset[1:0] != 2'b00)
              || (cur_addr < BASE_ADDR)
              || (offset[APB_ADDR_WIDTH-1:IDX_W+2] != '0)
              || (cur_nsec && idx[IDX_W-1]);
    end

    // FSM, wait counter and setup-phase capture.
    always_ff @(posedge PCLKM) begin
        if (PRESETM) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            nsec_q  <= 1'b0;
            strb_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= bus.PADDRM;
                write_q <= bus.PWRITEM;
                wdata_q <= bus.PWDATAM;
                nsec_q  <= bus.PPROTM[1];
                strb_q  <= bus.PSTRBM;
            end
        end
    end

    // Response registers and memory; the write lands on the same edge that
    // raises PREADYM, so a following read always sees it.
    always_ff @(posedge PCLKM) begin
        if (PRESETM) begin
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            for (int w = 0; w < MEM_DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (fire) begin
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= '0;
            if (cur_write) begin
                if (!err) begin
                    for (int i = 0; i < APB_STRB_WIDTH; i++) begin
                        if (cur_strb[i]) begin
                            mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                        end
                    end
                end
            end else if (!err) begin
                prdata <= mem[idx];
            end
        end else begin
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized self-checking bench for apb_mem_slave: one instance with two
// wait states and one with none, compared against an array-based model.
module tb_apb_mem_slave;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          WAIT_A = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        use_w0 = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [2:0]  pprot = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int tests = 0;
    int fails = 0;
    logic [31:0] ref_mem [2][DEPTH];

    always #5 clk = ~clk;

    apb_mem_slave_if bus_a ();
    apb_mem_slave_if bus_b ();

    assign bus_a.PSELM    = psel & ~use_w0;
    assign bus_b.PSELM    = psel & use_w0;
    assign bus_a.PENABLEM = penable;
    assign bus_b.PENABLEM = penable;
    assign bus_a.PADDRM   = paddr;
    assign bus_b.PADDRM   = paddr;
    assign bus_a.PWRITEM  = pwrite;
    assign bus_b.PWRITEM  = pwrite;
    assign bus_a.PWDATAM  = pwdata;
    assign bus_b.PWDATAM  = pwdata;
    assign bus_a.PPROTM   = pprot;
    assign bus_b.PPROTM   = pprot;
    assign bus_a.PSTRBM   = pstrb;
    assign bus_b.PSTRBM   = pstrb;

    assign prdata  = use_w0 ? bus_b.PRDATAM  : bus_a.PRDATAM;
    assign pready  = use_w0 ? bus_b.PREADYM  : bus_a.PREADYM;
    assign pslverr = use_w0 ? bus_b.PSLVERRM : bus_a.PSLVERRM;

    apb_mem_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT_A)) dut_a (
        .PCLKM(clk), .PRESETM(rst), .bus(bus_a)
    );
    apb_mem_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_b (
        .PCLKM(clk), .PRESETM(rst), .bus(bus_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                ref_mem[d][w] = '0;
    endtask

    // Drives a setup phase in the current cycle (caller sits at a negedge),
    // runs to completion and checks latency/response; returns at the
    // negedge of the completion cycle with PSELM/PENABLEM still high.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [2:0] prot, input logic [3:0] strb, output logic [31:0] rd);
        int k;
        int exp_lat;
        int d;
        int idx;
        longint a;
        logic exp_err;
        logic [31:0] exp_rd;
        d       = use_w0 ? 1 : 0;
        exp_lat = use_w0 ? 1 : WAIT_A + 1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
        pwdata = wd; pprot = prot; pstrb = strb;
        a   = longint'(addr);
        idx = 0;
        exp_err = (addr[1:0] != 2'b00) || (a < longint'(BASE)) ||
                  (a >= longint'(BASE) + 4 * DEPTH);
        if (!exp_err) begin
            idx = int'((a - longint'(BASE)) / 4);
            if (prot[1] && idx >= DEPTH / 2) exp_err = 1'b1;
        end
        exp_rd = (!wr && !exp_err) ? ref_mem[d][idx] : 32'h0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            penable = 1'b1;
            if (!pready) check_val("wait_quiet", {31'b0, pslverr} | prdata, 32'h0);
        end while (!pready && k < 20);
        check_val("latency", 32'(k), 32'(exp_lat));
        check_val("slverr", {31'b0, pslverr}, {31'b0, exp_err});
        if (!wr) check_val("rdata", prdata, exp_rd);
        rd = prdata;
        if (wr && !exp_err)
            for (int i = 0; i < 4; i++)
                if (strb[i]) ref_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
    endtask

    task automatic go_idle();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check_val("ready_one_cycle", {31'b0, pready}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        int seen;
        int r;
        clear_model();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'b0, pready}, 32'h0);
        check_val("rst_slverr", {31'b0, pslverr}, 32'h0);
        check_val("rst_rdata", prdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic write/read.
        xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 3'b000, 4'hF, rd); go_idle();
        xfer(32'h10, 1'b0, 32'h0, 3'b000, 4'h0, rd); go_idle();
        check_val("basic_read", rd, 32'hDEAD_BEEF);

        // Partial strobes.
        xfer(32'h20, 1'b1, 32'h1122_3344, 3'b000, 4'hF, rd); go_idle();
        xfer(32'h20, 1'b1, 32'hAABB_CCDD, 3'b000, 4'b0101, rd); go_idle();
        xfer(32'h20, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("strb_merge", rd, 32'h11BB_33DD);
        xfer(32'h20, 1'b1, 32'hFFFF_FFFF, 3'b000, 4'h0, rd); go_idle();
        xfer(32'h20, 1'b0, 32'h0, 3'b000, 4'h0, rd); go_idle();
        check_val("strb_zero", rd, 32'h11BB_33DD);

        // Error cases around the secure word at 0x200.
        xfer(32'h200, 1'b1, 32'h55AA_1234, 3'b000, 4'hF, rd); go_idle();
        xfer(32'h400, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("oor_rdata", rd, 32'h0);
        xfer(32'h06, 1'b1, 32'h0BAD_0BAD, 3'b000, 4'hF, rd); go_idle();
        xfer(32'h200, 1'b1, 32'h0BAD_0BAD, 3'b010, 4'hF, rd); go_idle();
        xfer(32'h200, 1'b0, 32'h0, 3'b010, 4'hF, rd); go_idle();
        check_val("ns_read_zero", rd, 32'h0);
        xfer(32'h200, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("secure_kept", rd, 32'h55AA_1234);
        xfer(32'h04, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("unaligned_kept", rd, 32'h0);
        xfer(32'hFFFF_FFFC, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();

        // Back-to-back on both instances.
        xfer(32'h50, 1'b1, 32'h0102_0304, 3'b000, 4'hF, rd);
        xfer(32'h50, 1'b0, 32'h0, 3'b000, 4'hF, rd);
        xfer(32'h54, 1'b1, 32'hA5A5_5A5A, 3'b000, 4'hF, rd);
        xfer(32'h54, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("b2b_read", rd, 32'hA5A5_5A5A);
        use_w0 = 1'b1;
        @(negedge clk);
        xfer(32'h60, 1'b1, 32'h7777_8888, 3'b000, 4'hF, rd);
        xfer(32'h60, 1'b0, 32'h0, 3'b000, 4'hF, rd);
        xfer(32'h3FC, 1'b1, 32'h1234_5678, 3'b010, 4'hF, rd); go_idle();
        check_val("w0_b2b_read", rd, 32'h0);
        xfer(32'h60, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("w0_read", rd, 32'h7777_8888);
        use_w0 = 1'b0;
        @(negedge clk);

        // Abort in the first access cycle of a write.
        xfer(32'h30, 1'b1, 32'hCAFE_F00D, 3'b000, 4'hF, rd); go_idle();
        psel = 1'b1; penable = 1'b0; paddr = 32'h30; pwrite = 1'b1;
        pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b000;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready) seen++;
        end
        check_val("abort_noready", 32'(seen), 32'h0);
        xfer(32'h30, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("abort_kept", rd, 32'hCAFE_F00D);

        // Random traffic on both instances.
        for (int n = 0; n < 110; n++) begin
            if (n == 80) begin
                use_w0 = 1'b1;
                @(negedge clk);
            end
            r = int'($urandom_range(0, 9));
            addr = {22'b0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            if (r == 0) addr = addr | 32'($urandom_range(1, 3));
            if (r == 1) addr = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
            if (r == 2) addr = 32'hFFFF_FFFC;
            xfer(addr, 1'($urandom_range(0, 1)), $urandom(), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), rd);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
        use_w0 = 1'b0;
        @(negedge clk);

        // Reset during the wait state of a write.
        xfer(32'h40, 1'b1, 32'h0A0B_0C0D, 3'b000, 4'hF, rd); go_idle();
        psel = 1'b1; penable = 1'b0; paddr = 32'h40; pwrite = 1'b1;
        pwdata = 32'hFEED_FACE; pstrb = 4'hF; pprot = 3'b000;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_ready", {31'b0, pready}, 32'h0);
        check_val("midrst_slverr", {31'b0, pslverr}, 32'h0);
        check_val("midrst_rdata", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        xfer(32'h40, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("midrst_cleared", rd, 32'h0);
        xfer(32'h10, 1'b0, 32'h0, 3'b000, 4'hF, rd); go_idle();
        check_val("rst_clears_other", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB completer sitting directly downstream of the bridge's master-side port, in the PCLKM domain.
- Consumes the PSELM/PENABLEM/PADDRM/PWRITEM/PWDATAM/PPROTM/PSTRBM request produced by the bridge.
- Returns PRDATAM/PREADYM/PSLVERRM from a word-addressed memory with byte strobes, fixed wait states and address/protection error checking.
- Serves as the bridge's system-level target and as the reference model target for the async bridge bench.

Parameters:
APB_ADDR_WIDTH, 32, address width
APB_DATA_WIDTH, 32, data width; only 32 supported
APB_STRB_WIDTH, APB_DATA_WIDTH/8, byte-strobe width
APB_PROT_WIDTH, 3, PPROT width
MEM_DEPTH, 256, number of 32-bit words; power of two, at least 4
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*MEM_DEPTH
WAIT_CYCLES, 2, wait states inserted before PREADYM; range 0..15

Ports:
PCLKM  input  1  clock
PRESETM  input  1  reset
PSELM  input  1  select
PENABLEM  input  1  enable (access phase)
PADDRM  input  APB_ADDR_WIDTH  byte address
PWRITEM  input  1  1=write, 0=read
PWDATAM  input  APB_DATA_WIDTH  write data
PPROTM  input  APB_PROT_WIDTH  protection; bit1=1 means non-secure
PSTRBM  input  APB_STRB_WIDTH  write byte strobes
PRDATAM  output  APB_DATA_WIDTH  read data
PREADYM  output  1  transfer complete
PSLVERRM  output  1  transfer error

Behaviour:
- One clock, PCLKM. Reset PRESETM is synchronous and active-high.
- All outputs are registered.
- Reset values: PRDATAM=0, PREADYM=0, PSLVERRM=0, FSM=IDLE, wait counter=0, all memory words=0.
- FSM states and transitions:
  - IDLE: on PSELM=1 and PENABLEM=0, latch PADDRM, PWRITEM, PWDATAM, PPROTM, PSTRBM and go to SETUP. PSELM=1 with PENABLEM=1 in IDLE is ignored.
  - SETUP: load counter=WAIT_CYCLES and go to ACCESS.
  - ACCESS: the counter decrements each cycle while non-zero. PREADYM is high in the cycle where counter==0.
- Latency: setup phase in cycle T gives PREADYM=1 in cycle T+1+WAIT_CYCLES, for exactly one cycle. Next state after that cycle is IDLE, or SETUP if PSELM=1 and PENABLEM=0 are sampled in that same completion cycle (back-to-back).
- Latched control is used for the whole transfer; input changes after the setup phase are ignored.
- Abort: PSELM=0 during ACCESS returns the FSM to IDLE next cycle. No write is committed and no PREADYM is issued.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits after range checking.
- Error (PSLVERRM=1 in the PREADYM cycle) when any of these holds:
  - addr[1:0] != 0;
  - addr < BASE_ADDR or addr >= BASE_ADDR + 4*MEM_DEPTH;
  - PPROTM[1]=1 and the word index is >= MEM_DEPTH/2 (the secure upper half).
- Write without error: in the PREADYM cycle, each byte lane i with strobe bit i set is updated; lanes with the strobe clear are untouched. PSTRBM=0 is a legal no-op with no error.
- Errored write: memory is unchanged.
- Read without error: PRDATAM holds the word contents in the PREADYM cycle. PSTRBM is ignored on reads.
- Errored read: PRDATAM=0.
- PRDATAM=0 and PSLVERRM=0 in every cycle where PREADYM=0.
- Reset mid-transfer: the FSM goes to IDLE and outputs return to reset values at the reset edge. The pending write is dropped and memory is cleared.
- Wrap-around: no address wrap. Addresses past the top of the memory are errors, never aliases.

Test Plan:
- Reset release, WAIT_CYCLES=2, write 32'hDEAD_BEEF to 0x10 with PSTRBM=4'hF, then read 0x10 -> PREADYM rises 3 cycles after each setup cycle; read returns 32'hDEAD_BEEF with PSLVERRM=0.
- Write 32'h1122_3344 to 0x20 with PSTRBM=4'hF, then write 32'hAABB_CCDD to 0x20 with PSTRBM=4'b0101, then read 0x20 -> 32'h11BB_33DD.
- Out-of-range read at 0x400 (MEM_DEPTH=256), unaligned write at 0x06, and non-secure (PPROTM=3'b010) write to 0x200 -> each gets PSLVERRM=1 together with PREADYM. Read data is 0 and memory is unchanged; a secure read of 0x200 returns the prior value.
- Back-to-back: the completion cycle is immediately followed by a new setup (PSELM=1, PENABLEM=0) -> the second transfer's PREADYM arrives WAIT_CYCLES+1 cycles later with no idle gap required. Also rebuild with WAIT_CYCLES=0 -> PREADYM in the first access cycle.
- Abort: PSELM is dropped in the first access cycle of a write to 0x30 -> no PREADYM; a later read of 0x30 returns the old value.
- PRESETM asserted during the wait state of a write -> all outputs 0 on the next edge; a subsequent read of that address returns 0.
